// File: rtl/pat_checker.sv
// Pattern-sink checker: terminates the pattern generator's AXI-Stream and
// checks each packet's payload, length and header-ID sequence. It keeps
// saturating good/bad packet counters and sticky error flags.

// One lane compare: flags a 32-bit lane that differs from its expected word.
module pat_lane_cmp (
  input  logic [31:0] i_lane,
  input  logic [31:0] i_exp,
  output logic        o_bad
);
  assign o_bad = (i_lane != i_exp);
endmodule

module pat_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int PACKET_BEATS = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clear_stats,
  input  logic [DATA_WIDTH-1:0]  AXIS_RX_TDATA,
  input  logic                   AXIS_RX_TVALID,
  input  logic                   AXIS_RX_TLAST,
  output logic                   AXIS_RX_TREADY,
  output logic [31:0]            packet_id,
  output logic [COUNT_WIDTH-1:0] good_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic                   err_data,
  output logic                   err_length,
  output logic                   err_sequence,
  output logic                   in_sync
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int IDX_W = $clog2(PACKET_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BEATS - 1);

  typedef enum logic [1:0] {S_HEADER, S_BODY, S_DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [31:0]            r_hdr, w_hdr_nxt;
  logic [31:0]            r_exp_id;
  logic                   r_pe_data, r_pe_len, r_pe_seq;
  logic                   w_pe_data_nxt, w_pe_len_nxt, w_pe_seq_nxt;
  logic                   w_done;
  logic                   w_accept;
  logic [31:0]            w_lane0;
  logic [31:0]            w_exp_val;
  logic [LANES-1:0]       w_lane_bad;
  logic                   w_beat_bad;
  logic                   w_pkt_bad;

  logic [31:0]            r_packet_id;
  logic [COUNT_WIDTH-1:0] r_good, r_bad;
  logic                   r_f_data, r_f_len, r_f_seq, r_in_sync;

  assign AXIS_RX_TREADY = ~reset & ~stall;
  assign w_accept       = AXIS_RX_TVALID & AXIS_RX_TREADY;
  assign w_lane0        = AXIS_RX_TDATA[31:0];
  // On the header beat the reference is lane 0 itself, so lane 0 can never
  // mismatch and the other lanes are checked against it.
  assign w_exp_val      = (r_state == S_HEADER) ? w_lane0 : (r_hdr + 32'(r_idx));

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    pat_lane_cmp u_cmp (
      .i_lane (AXIS_RX_TDATA[32*j +: 32]),
      .i_exp  (w_exp_val),
      .o_bad  (w_lane_bad[j])
    );
  end
  assign w_beat_bad = |w_lane_bad;
  assign w_pkt_bad  = w_pe_data_nxt | w_pe_len_nxt | w_pe_seq_nxt;

  // Next-state, beat index and per-packet error bits for the accepted beat.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_hdr_nxt     = r_hdr;
    w_pe_data_nxt = r_pe_data;
    w_pe_len_nxt  = r_pe_len;
    w_pe_seq_nxt  = r_pe_seq;
    w_done        = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HEADER: begin
          w_hdr_nxt     = w_lane0;
          w_idx_nxt     = IDX_W'(1);
          w_pe_data_nxt = w_beat_bad;
          w_pe_len_nxt  = 1'b0;
          w_pe_seq_nxt  = r_in_sync & (w_lane0 != r_exp_id);
          if (AXIS_RX_TLAST) begin
            w_pe_len_nxt = 1'b1;
            w_done       = 1'b1;
          end else begin
            w_state_nxt = S_BODY;
          end
        end
        S_BODY: begin
          w_pe_data_nxt = r_pe_data | w_beat_bad;
          if (r_idx == LAST_IDX) begin
            if (AXIS_RX_TLAST) begin
              w_done = 1'b1;
            end else begin
              w_pe_len_nxt = 1'b1;
              w_state_nxt  = S_DRAIN;
            end
          end else if (AXIS_RX_TLAST) begin
            w_pe_len_nxt = 1'b1;
            w_done       = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (AXIS_RX_TLAST) w_done = 1'b1;
        end
        default: w_state_nxt = S_HEADER;
      endcase
      if (w_done) w_state_nxt = S_HEADER;
    end
  end

  // Packet tracking state: FSM, header, expected ID and per-packet errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HEADER;
      r_idx       <= '0;
      r_hdr       <= '0;
      r_exp_id    <= '0;
      r_pe_data   <= 1'b0;
      r_pe_len    <= 1'b0;
      r_pe_seq    <= 1'b0;
      r_packet_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hdr   <= w_hdr_nxt;
      if (w_done) begin
        r_packet_id <= w_hdr_nxt;
        r_exp_id    <= w_hdr_nxt + 32'd1;
        r_idx       <= '0;
        r_pe_data   <= 1'b0;
        r_pe_len    <= 1'b0;
        r_pe_seq    <= 1'b0;
      end else begin
        r_pe_data <= w_pe_data_nxt;
        r_pe_len  <= w_pe_len_nxt;
        r_pe_seq  <= w_pe_seq_nxt;
      end
    end
  end

  // Status: saturating counters, sticky flags and sync; clear beats completion.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_good    <= '0;
      r_bad     <= '0;
      r_f_data  <= 1'b0;
      r_f_len   <= 1'b0;
      r_f_seq   <= 1'b0;
      r_in_sync <= 1'b0;
    end else if (w_done) begin
      r_in_sync <= 1'b1;
      if (w_pkt_bad) begin
        if (r_bad != '1) r_bad <= r_bad + COUNT_WIDTH'(1);
      end else begin
        if (r_good != '1) r_good <= r_good + COUNT_WIDTH'(1);
      end
      r_f_data <= r_f_data | w_pe_data_nxt;
      r_f_len  <= r_f_len  | w_pe_len_nxt;
      r_f_seq  <= r_f_seq  | w_pe_seq_nxt;
    end
  end

  assign packet_id    = r_packet_id;
  assign good_count   = r_good;
  assign error_count  = r_bad;
  assign err_data     = r_f_data;
  assign err_length   = r_f_len;
  assign err_sequence = r_f_seq;
  assign in_sync      = r_in_sync;
endmodule

// File: tb/tb_pat_checker.sv
// Scoreboard bench for pat_checker (64-bit data, 4-beat packets).
module tb_pat_checker;
  localparam int DW = 64;
  localparam int PB = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, stall, clear_stats;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready;
  logic [31:0]   pid;
  logic [CW-1:0] good, errc;
  logic          e_data, e_len, e_seq, sync;

  pat_checker #(.DATA_WIDTH(DW), .PACKET_BEATS(PB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clear_stats(clear_stats),
    .AXIS_RX_TDATA(tdata), .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast),
    .AXIS_RX_TREADY(tready), .packet_id(pid), .good_count(good),
    .error_count(errc), .err_data(e_data), .err_length(e_len),
    .err_sequence(e_seq), .in_sync(sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pid;
    logic [31:0] good;
    logic [31:0] bad;
    logic [2:0]  flags;  // {data, length, sequence}
    logic        sync;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   nbad  = 0;
  bit   stall_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input logic [31:0] p, input logic [31:0] g, input logic [31:0] b,
                            input logic [2:0] f, input logic s);
    exp_t e;
    e.pid = p; e.good = g; e.bad = b; e.flags = f; e.sync = s;
    q.push_back(e);
  endtask

  // Monitor: a completion is an accepted TLAST beat; results are registered,
  // so compare on the following falling edge.
  exp_t m_e;
  always @(posedge clk) begin
    if (tvalid && tready && tlast) begin
      @(negedge clk);
      if (q.size() == 0) begin
        total++; nbad++;
        $display("FAIL unexpected_completion: pid=%h", pid);
      end else begin
        m_e = q.pop_front();
        chk("packet_id",   pid,                   m_e.pid);
        chk("good_count",  good,                  m_e.good);
        chk("error_count", errc,                  m_e.bad);
        chk("flags",       {29'd0, e_data, e_len, e_seq}, {29'd0, m_e.flags});
        chk("in_sync",     {31'd0, sync},         {31'd0, m_e.sync});
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input logic [31:0] l0, input logic [31:0] l1, input logic last, input logic clr);
    int n   = 0;
    bit acc = 0;
    tdata = {l1, l0}; tlast = last; tvalid = 1'b1; clear_stats = clr;
    while (!acc && n < 200) begin
      if (stall_en) begin
        stall = 1'($urandom_range(0, 1));
        #1;
        chk("tready_vs_stall", {31'd0, tready}, {31'd0, ~stall});
      end
      @(posedge clk);
      acc = tready;
      n++;
      @(negedge clk);
    end
    clear_stats = 1'b0;
    if (!acc) begin
      total++; nbad++;
      $display("FAIL beat_timeout: accepted=%0d required=1", acc);
    end
  endtask

  // Packet of nb beats with ID h; beat bad_k gets lane 1 corrupted.
  task automatic send_pkt(input logic [31:0] h, input int nb, input int bad_k, input bit clr_last);
    for (int k = 0; k < nb; k++) begin
      logic [31:0] v;
      v = h + 32'(k);
      beat(v, (k == bad_k) ? 32'hDEADBEEF : v, (k == nb - 1), clr_last && (k == nb - 1));
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic do_clear();
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; clear_stats = 1'b0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready",  {31'd0, tready}, 32'd0);
    chk("rst_pid",     pid,  32'd0);
    chk("rst_good",    good, 32'd0);
    chk("rst_err",     errc, 32'd0);
    chk("rst_flags",   {29'd0, e_data, e_len, e_seq}, 32'd0);
    chk("rst_sync",    {31'd0, sync}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("tready_idle", {31'd0, tready}, 32'd1);

    // Clean packets 5,6,7
    expect_pkt(5, 1, 0, 3'b000, 1); send_pkt(5, 4, -1, 0);
    expect_pkt(6, 2, 0, 3'b000, 1); send_pkt(6, 4, -1, 0);
    expect_pkt(7, 3, 0, 3'b000, 1); send_pkt(7, 4, -1, 0);

    // Data error, then clean
    do_clear();
    expect_pkt(10, 0, 1, 3'b100, 1); send_pkt(10, 4, 2, 0);
    expect_pkt(11, 1, 1, 3'b100, 1); send_pkt(11, 4, -1, 0);

    // Short then long, then clean
    do_clear();
    expect_pkt(20, 0, 1, 3'b010, 1); send_pkt(20, 2, -1, 0);
    expect_pkt(21, 0, 2, 3'b010, 1); send_pkt(21, 6, -1, 0);
    expect_pkt(22, 1, 2, 3'b010, 1); send_pkt(22, 4, -1, 0);

    // Sequence gap, resync, and no sequence error after clear
    do_clear();
    expect_pkt(30, 1, 0, 3'b000, 1); send_pkt(30, 4, -1, 0);
    expect_pkt(32, 1, 1, 3'b001, 1); send_pkt(32, 4, -1, 0);
    expect_pkt(33, 2, 1, 3'b001, 1); send_pkt(33, 4, -1, 0);
    do_clear();
    expect_pkt(100, 1, 0, 3'b000, 1); send_pkt(100, 4, -1, 0);

    // Random backpressure over 8 clean packets
    do_clear();
    stall_en = 1;
    for (int i = 0; i < 8; i++) begin
      expect_pkt(200 + i, i + 1, 0, 3'b000, 1);
      send_pkt(200 + i, 4, -1, 0);
    end
    stall_en = 0; stall = 1'b0;
    @(negedge clk);

    // Clear coinciding with a bad packet's completion
    do_clear();
    expect_pkt(208, 0, 0, 3'b000, 0); send_pkt(208, 4, 2, 1);

    // Reset in the middle of a packet, then a clean packet
    beat(50, 50, 0, 0);
    beat(51, 51, 0, 0);
    tdata = {32'd52, 32'd52}; tvalid = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_tready", {31'd0, tready}, 32'd0);
    tvalid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_good", good, 32'd0);
    chk("mid_rst_pid",  pid,  32'd0);
    expect_pkt(60, 1, 0, 3'b000, 1); send_pkt(60, 4, -1, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule

// File: doc/pat_checker.md
Name: pat_checker

Overview:
- Parametrised successor to the pattern-sink stage: terminates the AXI-Stream output of the pattern generator, and checks each packet's payload, length and packet-ID sequence.
- Keeps good-packet and bad-packet counters plus sticky error flags for status readout.
- Supports receive-side backpressure through a stall input, so flow control can be exercised.

Parameters:
- DATA_WIDTH, 64, TDATA width in bits; a multiple of 32, minimum 32; LANES = DATA_WIDTH/32.
- PACKET_BEATS, 16, expected beats per packet including the header beat; minimum 2.
- COUNT_WIDTH, 32, width of the packet and error counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when 1, AXIS_RX_TREADY is driven 0.
- clear_stats  in  1  single-cycle pulse; clears counters, flags and sync.
- AXIS_RX_TDATA  in  DATA_WIDTH  stream data; lane j = bits [32j+31:32j].
- AXIS_RX_TVALID  in  1  stream valid.
- AXIS_RX_TLAST  in  1  marks the last beat of a packet.
- AXIS_RX_TREADY  out  1  equals (not reset) and (not stall); combinational.
- packet_id  out  32  header ID of the most recently completed packet, good or bad.
- good_count  out  COUNT_WIDTH  packets that completed with no error.
- error_count  out  COUNT_WIDTH  packets that completed with one or more errors.
- err_data  out  1  sticky: payload mismatch seen.
- err_length  out  1  sticky: short or long packet seen.
- err_sequence  out  1  sticky: packet-ID discontinuity seen.
- in_sync  out  1  1 once at least one packet has completed since the last reset or clear.

Behaviour:
- Beat accept = AXIS_RX_TVALID and AXIS_RX_TREADY. Nothing advances on a cycle without an accept.
- Packet format:
  - beat 0, lane 0 is the header ID H;
  - every lane of beat k (0 <= k < PACKET_BEATS) must equal (H + k) mod 2^32, so beat 0 lanes 1..LANES-1 must also equal H;
  - any lane mismatch sets the packet's data-error bit.
- States: S_HEADER, S_BODY, S_DRAIN. Reset state is S_HEADER.
- S_HEADER:
  - on accept, latch H and set beat index = 1;
  - check the lanes of beat 0;
  - if TLAST is set, the packet is short: complete it and stay in S_HEADER; else go to S_BODY.
- S_BODY:
  - on accept, check the lanes against H + index.
  - TLAST with index < PACKET_BEATS-1: short; complete and return to S_HEADER.
  - index = PACKET_BEATS-1 with TLAST: good length; complete and return to S_HEADER.
  - index = PACKET_BEATS-1 without TLAST: long; set the length-error bit, do not complete, go to S_DRAIN.
  - otherwise increment index.
- S_DRAIN: accept and discard beats with no data checks. On TLAST, complete and return to S_HEADER.
- Sequence check: if in_sync = 1 and H != expected_id, set the sequence-error bit. After every completion, expected_id = H + 1 (resynchronise). The first packet after reset or clear is never a sequence error.
- Completion, with all outputs registered and valid the cycle after the completing accept:
  - packet_id <= H;
  - in_sync <= 1;
  - if no error bit is set, good_count increments; else error_count increments by exactly 1, regardless of how many error types occurred;
  - each set error bit ORs into its sticky flag;
  - per-packet error bits clear.
- Counters saturate at all-ones; they do not wrap.
- clear_stats:
  - clears good_count, error_count, the three sticky flags and in_sync;
  - does not clear packet_id, expected_id or the FSM state, so the packet in flight continues to be checked.
  - If clear_stats coincides with a completion, clear wins: the counter and flag updates are dropped, in_sync ends at 0, and packet_id and expected_id still update.
- Reset values: packet_id = 0, counters = 0, flags = 0, in_sync = 0, state = S_HEADER, index = 0, expected_id = 0, AXIS_RX_TREADY = 0.
- Reset mid-packet abandons the partial packet with no count. The next beat is treated as a header.
- stall: TREADY drops in the same cycle; state is frozen while stalled.

Test Plan:
- DATA_WIDTH=64, PACKET_BEATS=4; send IDs 5,6,7 with correct payload (beat 2 = 0x00000007/0x00000007 for H=5) -> good_count=3, error_count=0, packet_id=7, all flags 0, in_sync=1.
- ID 10 with beat 2 lane 1 = 0xDEADBEEF -> err_data=1, error_count=1, good_count unchanged; next packet ID 11 clean -> good_count+1.
- ID 20 with TLAST on beat 1 (short), then ID 21 with 6 beats (long) -> err_length=1, error_count=2, FSM in S_HEADER after beat 5 of ID 21; ID 22 clean -> good.
- IDs 30, 32 -> err_sequence=1 at ID 32, error_count=1; ID 33 -> good (resync). Also: clear_stats, then ID 100 -> no sequence error.
- Random stall toggling (50%) across 8 back-to-back clean packets -> TREADY = !stall every cycle, good_count=8.
- clear_stats on the completing beat of a bad packet -> counters 0, flags 0, in_sync=0, packet_id = that ID. Reset asserted at beat 2, then a clean packet -> good_count=1.
